// File: rtl/ts_write_sched.sv
// Write scheduler for the shared sound-chip bus (YM1, YM2, SAA1099): buffers host
// writes and replays them in order with a fixed setup/strobe/hold shape and per-chip recovery.
module ts_write_sched #(
    parameter int FIFO_DEPTH   = 8,
    parameter int SETUP        = 2,
    parameter int WR_PULSE     = 4,
    parameter int HOLD         = 2,
    parameter int YM_ADDR_WAIT = 160,
    parameter int YM_DATA_WAIT = 780,
    parameter int SAA_WAIT     = 8
) (
    input  logic       clk32,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_chip,
    input  logic       req_a0,
    input  logic [7:0] req_data,
    output logic       req_ready,
    input  logic       flush,
    output logic       busy,
    output logic       err_drop,
    output logic [2:0] bus_cs_n,
    output logic       bus_a0,
    output logic       bus_wr_n,
    output logic [7:0] bus_d,
    output logic       bus_d_oe,
    output logic [1:0] dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Phase counter covers SETUP/WR_PULSE/HOLD values up to 256 cycles.
    localparam int PW = 8;

    typedef struct packed {
        logic [1:0] chip;
        logic       a0;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    // Handshake: a request transfers on every clk32 edge where req_valid && req_ready;
    // req_ready depends only on FIFO fullness and rst, never on req_valid.
    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            head_vld;
    entry_t          head;
    logic            full;
    logic            accept;
    logic            push;
    logic            pop;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   phase;
    logic            go;
    logic            hold_done;
    logic            pop_ok;
    entry_t          tx_q;
    entry_t          tx_nxt;

    logic [9:0]      tmr [3];
    logic [9:0]      head_tmr;
    logic [9:0]      tmr_load;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign req_ready = !full && !rst;
    assign accept    = req_valid && req_ready;
    assign push      = accept && (req_chip != 2'd3);
    assign pop       = hold_done && pop_ok;
    assign head      = mem[rd_ptr];
    assign busy      = (count != '0) || (state != ST_IDLE);
    assign dbg_state = state;
    assign tx_nxt    = go ? head : tx_q;

    always_ff @(posedge clk32) begin
        if (push) begin
            mem[wr_ptr] <= '{chip: req_chip, a0: req_a0, data: req_data};
        end
    end

    // head_vld lags the FIFO by one cycle so a freshly pushed entry is seen a cycle later,
    // while an entry that was already queued behind a popped head is eligible at once.
    always_ff @(posedge clk32) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_vld <= 1'b0;
        end else if (flush) begin
            rd_ptr   <= wr_ptr;
            wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
            count    <= push ? CW'(1) : '0;
            head_vld <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            head_vld <= pop ? (count >= CW'(2)) : (count != '0);
        end
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            err_drop <= 1'b0;
        end else begin
            err_drop <= accept && (req_chip == 2'd3);
        end
    end

    always_comb begin
        case (head.chip)
            2'd1:    head_tmr = tmr[1];
            2'd2:    head_tmr = tmr[2];
            default: head_tmr = tmr[0];
        endcase
    end

    always_comb begin
        if (tx_q.chip == 2'd2) begin
            tmr_load = 10'(SAA_WAIT);
        end else if (tx_q.a0) begin
            tmr_load = 10'(YM_DATA_WAIT);
        end else begin
            tmr_load = 10'(YM_ADDR_WAIT);
        end
    end

    always_ff @(posedge clk32) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                tmr[i] <= '0;
            end else if (hold_done && (tx_q.chip == 2'(i))) begin
                tmr[i] <= tmr_load;
            end else if (tmr[i] != '0) begin
                tmr[i] <= tmr[i] - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        hold_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (head_vld && (head_tmr == '0)) begin
                    state_nxt = ST_SETUP;
                    go        = 1'b1;
                end
            end
            ST_SETUP: begin
                if (phase == PW'(SETUP - 1)) begin
                    state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (phase == PW'(WR_PULSE - 1)) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (phase == PW'(HOLD - 1)) begin
                    state_nxt = ST_IDLE;
                    hold_done = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            state <= ST_IDLE;
            phase <= '0;
        end else begin
            state <= state_nxt;
            phase <= (state_nxt != state) ? '0 : phase + 1'b1;
        end
    end

    // A flush while the transaction is in flight means its FIFO slot is already gone.
    always_ff @(posedge clk32) begin
        if (rst) begin
            tx_q   <= '0;
            pop_ok <= 1'b0;
        end else begin
            if (go) begin
                tx_q   <= head;
                pop_ok <= !flush;
            end else if (flush) begin
                pop_ok <= 1'b0;
            end
        end
    end

    // Bus pins are registered from the next state so CS rises/falls on the state edge.
    always_ff @(posedge clk32) begin
        if (rst) begin
            bus_cs_n <= 3'b111;
            bus_wr_n <= 1'b1;
            bus_d_oe <= 1'b0;
            bus_d    <= '0;
            bus_a0   <= 1'b0;
        end else if (state_nxt != ST_IDLE) begin
            bus_cs_n <= ~(3'b001 << tx_nxt.chip);
            bus_wr_n <= (state_nxt != ST_STROBE);
            bus_d_oe <= 1'b1;
            bus_d    <= tx_nxt.data;
            bus_a0   <= tx_nxt.a0;
        end else begin
            bus_cs_n <= 3'b111;
            bus_wr_n <= 1'b1;
            bus_d_oe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ts_write_sched.sv
// Directed bench for ts_write_sched: bus shapes, recovery spacing, ordering,
// FIFO back-pressure, invalid-chip drop, flush and mid-strobe reset.
module tb_ts_write_sched;

    logic       clk32 = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_chip;
    logic       req_a0;
    logic [7:0] req_data;
    logic       req_ready;
    logic       flush;
    logic       busy;
    logic       err_drop;
    logic [2:0] bus_cs_n;
    logic       bus_a0;
    logic       bus_wr_n;
    logic [7:0] bus_d;
    logic       bus_d_oe;
    logic [1:0] dbg_state;

    int n_total = 0;
    int n_pass  = 0;
    int k;
    int stall;
    int act;

    logic [11:0] exp_q[$];
    logic [11:0] mon_q[$];
    logic [11:0] e_got;
    logic [11:0] e_exp;

    ts_write_sched dut (
        .clk32     (clk32),
        .rst       (rst),
        .req_valid (req_valid),
        .req_chip  (req_chip),
        .req_a0    (req_a0),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .busy      (busy),
        .err_drop  (err_drop),
        .bus_cs_n  (bus_cs_n),
        .bus_a0    (bus_a0),
        .bus_wr_n  (bus_wr_n),
        .bus_d     (bus_d),
        .bus_d_oe  (bus_d_oe),
        .dbg_state (dbg_state)
    );

    always #5 clk32 = ~clk32;

    // Record {cs_n, a0, data} at the start of every bus transaction.
    logic [2:0] prev_cs = 3'b111;
    always @(negedge clk32) begin
        if (!$isunknown(bus_cs_n)) begin
            if (prev_cs == 3'b111 && bus_cs_n != 3'b111) begin
                mon_q.push_back({bus_cs_n, bus_a0, bus_d});
            end
            prev_cs <= bus_cs_n;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [1:0] chip, input logic a0, input logic [7:0] d);
        req_valid = 1'b1;
        req_chip  = chip;
        req_a0    = a0;
        req_data  = d;
        tick();
        req_valid = 1'b0;
    endtask

    // Checks transaction cycle n (1..8), then advances one cycle.
    task automatic check_cycle(input int n, input logic [2:0] cs, input logic a0, input logic [7:0] d);
        check($sformatf("cyc%0d_cs", n), bus_cs_n, cs);
        check($sformatf("cyc%0d_wr_n", n), bus_wr_n, (n >= 3 && n <= 6) ? 1'b0 : 1'b1);
        check($sformatf("cyc%0d_d", n), bus_d, d);
        check($sformatf("cyc%0d_a0", n), bus_a0, a0);
        check($sformatf("cyc%0d_oe", n), bus_d_oe, 1'b1);
        tick();
    endtask

    task automatic wait_cs(input int budget, output int cnt);
        cnt = 0;
        while (bus_cs_n === 3'b111 && cnt < budget) begin
            tick();
            cnt++;
        end
    endtask

    task automatic count_activity(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus_cs_n !== 3'b111) hits++;
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_chip  = 2'd0;
        req_a0    = 1'b0;
        req_data  = 8'h00;
        flush     = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check("rst_cs", bus_cs_n, 3'b111);
        check("rst_wr_n", bus_wr_n, 1'b1);
        check("rst_oe", bus_d_oe, 1'b0);
        check("rst_d", bus_d, 8'h00);
        check("rst_a0", bus_a0, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_drop, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", req_ready, 1'b1);

        // YM1 address then data write: 160-cycle recovery between them
        send(2'd0, 1'b0, 8'h07);
        check("lat_n1_cs", bus_cs_n, 3'b111);
        send(2'd0, 1'b1, 8'h38);
        check("lat_n2_cs", bus_cs_n, 3'b111);
        tick();
        for (int n = 1; n <= 8; n++) check_cycle(n, 3'b110, 1'b0, 8'h07);
        check("ym_exit_cs", bus_cs_n, 3'b111);
        check("ym_exit_oe", bus_d_oe, 1'b0);
        check("ym_exit_d_hold", bus_d, 8'h07);
        check("ym_exit_busy", busy, 1'b1);
        wait_cs(400, k);
        check("ym_addr_gap", k, 161);
        for (int n = 1; n <= 8; n++) check_cycle(n, 3'b110, 1'b1, 8'h38);
        check("ym2nd_busy", busy, 1'b0);

        // YM1 data write waits 780 after the previous; SAA queued behind issues right after
        send(2'd0, 1'b1, 8'hA5);
        send(2'd2, 1'b0, 8'h1C);
        wait_cs(1000, k);
        check("ym_data_gap", k, 779);
        for (int n = 1; n <= 8; n++) check_cycle(n, 3'b110, 1'b1, 8'hA5);
        wait_cs(50, k);
        check("saa_after_ym", k, 1);
        for (int n = 1; n <= 8; n++) check_cycle(n, 3'b011, 1'b0, 8'h1C);
        check("saa_done_busy", busy, 1'b0);
        check("saa_done_cs", bus_cs_n, 3'b111);

        // Invalid chip: dropped with a one-cycle err_drop pulse
        send(2'd3, 1'b0, 8'hFF);
        check("drop_err_hi", err_drop, 1'b1);
        check("drop_busy", busy, 1'b0);
        tick();
        check("drop_err_lo", err_drop, 1'b0);
        count_activity(12, act);
        check("drop_no_cs", act, 0);

        // Nine YM2 writes into an 8-deep FIFO
        mon_q.delete();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            req_valid = 1'b1;
            req_chip  = 2'd1;
            req_a0    = 1'b0;
            req_data  = 8'h40 + 8'(i);
            stall = 0;
            while (req_ready !== 1'b1 && stall < 50) begin
                tick();
                stall++;
            end
            check($sformatf("fill%0d_stall", i), stall, (i == 8) ? 3 : 0);
            exp_q.push_back({3'b101, 1'b0, req_data});
            tick();
            if (i == 7) check("full_ready", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 3000) begin
            tick();
            k++;
        end
        check("fill_drain", busy, 1'b0);
        check("fill_count", mon_q.size(), 9);
        while (exp_q.size() > 0) begin
            e_exp = exp_q.pop_front();
            e_got = (mon_q.size() > 0) ? mon_q.pop_front() : 12'h000;
            check("fill_order", e_got, e_exp);
        end

        // Flush during the first transaction's strobe
        send(2'd2, 1'b0, 8'h11);
        send(2'd2, 1'b1, 8'h22);
        send(2'd2, 1'b0, 8'h33);
        send(2'd2, 1'b1, 8'h44);
        check_cycle(2, 3'b011, 1'b0, 8'h11);
        flush = 1'b1;
        check_cycle(3, 3'b011, 1'b0, 8'h11);
        flush = 1'b0;
        check("flush_inflight_busy", busy, 1'b1);
        for (int n = 4; n <= 8; n++) check_cycle(n, 3'b011, 1'b0, 8'h11);
        check("flush_done_busy", busy, 1'b0);
        check("flush_done_cs", bus_cs_n, 3'b111);
        count_activity(30, act);
        check("flush_no_issue", act, 0);

        // Reset in the middle of a strobe
        send(2'd2, 1'b1, 8'h99);
        send(2'd2, 1'b0, 8'h66);
        tick();
        check_cycle(1, 3'b011, 1'b1, 8'h99);
        check_cycle(2, 3'b011, 1'b1, 8'h99);
        check("mid_strobe_wr_n", bus_wr_n, 1'b0);
        rst = 1'b1;
        tick();
        check("abort_wr_n", bus_wr_n, 1'b1);
        check("abort_cs", bus_cs_n, 3'b111);
        check("abort_oe", bus_d_oe, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", req_ready, 1'b0);
        check("abort_state", dbg_state, 2'd0);
        rst = 1'b0;
        tick();
        check("abort_ready_after", req_ready, 1'b1);
        count_activity(20, act);
        check("abort_no_issue", act, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ts_write_sched.md
# ts_write_sched

Write scheduler for the shared external sound-chip bus (YM1, YM2, SAA1099) on the Sizif-512 extension CPLD. It buffers host I/O writes so the Z80 is never throttled by YM recovery times. Each buffered write is replayed onto the bus with a fixed setup/strobe/hold shape. Each target chip has its own recovery timer, so a slow YM write does not block writes to the other chips. The block sits between the host port decoder (FFFD/BFFD/FF) and the `ad`/`aa0`/`n_awr`/chip-select pins.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: write buffer entries; power of two, 2..16.
- `SETUP`, 2: `clk32` cycles with CS, A0 and data valid before the write strobe.
- `WR_PULSE`, 4: `clk32` cycles with the write strobe low.
- `HOLD`, 2: `clk32` cycles with CS and data held after the strobe.
- `YM_ADDR_WAIT`, 160: YM recovery after an A0=0 write, in `clk32` cycles.
- `YM_DATA_WAIT`, 780: YM recovery after an A0=1 write; must be ≤1023.
- `SAA_WAIT`, 8: SAA recovery after any write.

Ports:
- `clk32` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: host write request.
- `req_chip` in 2: target chip; 0=YM1, 1=YM2, 2=SAA, 3=invalid.
- `req_a0` in 1: register-select bit for the target chip.
- `req_data` in 8: write data.
- `req_ready` out 1: request accepted on a cycle where `req_valid && req_ready`.
- `flush` in 1: discard all queued entries.
- `busy` out 1: FIFO not empty or a bus transaction is in flight.
- `err_drop` out 1: one-cycle pulse when a `req_chip`=3 request is accepted.
- `bus_cs_n` out 3: active-low chip selects; bit 0=YM1, bit 1=YM2, bit 2=SAA.
- `bus_a0` out 1: A0 to the chip.
- `bus_wr_n` out 1: active-low write strobe.
- `bus_d` out 8: data to the chip.
- `bus_d_oe` out 1: data output enable for the `ad` pins.

## Operation
- FIFO:
  - Each entry is {chip[1:0], a0, data[7:0]}.
  - `req_ready` = !full && !rst.
  - No push while full, even if a pop occurs in the same cycle.
  - A chip=3 request is accepted, not stored, and pulses `err_drop` on the next cycle.
- Recovery timers: three 10-bit down-counters, `tmr[0..2]`. Each decrements by 1 per cycle while nonzero.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE → SETUP when the FIFO is non-empty and `tmr[head.chip]==0`. The head entry is latched into the transaction register; it is not popped yet.
  - SETUP → STROBE after `SETUP` cycles.
  - STROBE → HOLD after `WR_PULSE` cycles.
  - HOLD → IDLE after `HOLD` cycles. On that exit cycle:
    - The head entry is popped.
    - `tmr[chip]` is loaded with `YM_ADDR_WAIT` (YM, a0=0), `YM_DATA_WAIT` (YM, a0=1) or `SAA_WAIT` (SAA).
- Ordering:
  - Issue is strictly in order: only the head may issue.
  - If the head's chip is still recovering, later entries wait behind it.
  - A head targeting a different, idle chip issues immediately.
- Bus outputs (all registered):
  - `bus_cs_n[chip]`=0, `bus_a0`, `bus_d` and `bus_d_oe`=1 are driven in every SETUP, STROBE and HOLD cycle.
  - `bus_wr_n`=0 only in STROBE.
  - In IDLE: `bus_cs_n`=3'b111, `bus_wr_n`=1, `bus_d_oe`=0; `bus_d` and `bus_a0` hold their last values.
- Flush:
  - `flush` empties the FIFO in the cycle it is sampled; the in-flight entry is excluded.
  - An in-flight transaction completes its full shape, then pops nothing and loads its timer normally.
  - If `flush` and a push occur in the same cycle, the push is kept.
- Reset (synchronous, active-high):
  - FIFO empty, FSM in IDLE, all timers 0.
  - `bus_cs_n`=3'b111, `bus_wr_n`=1, `bus_d_oe`=0, `bus_d`=0, `bus_a0`=0.
  - `busy`=0, `err_drop`=0, `req_ready`=0 while `rst`=1 and 1 on the first cycle after.
  - Reset asserted mid-transaction aborts it immediately; the strobe is released within one cycle.

## Timing
- Accept at edge N. The entry is at the head by N+1. IDLE sees it and enters SETUP at edge N+2 (earliest), with CS low from N+2.
- A bus transaction lasts exactly SETUP+WR_PULSE+HOLD = 8 cycles with defaults. `bus_wr_n` is low for cycles 3–6 of the transaction.
- Back-to-back writes to different idle chips: one IDLE cycle between transactions, so a 9-cycle pitch.
- Same chip: the next SETUP starts exactly wait+1 cycles after the HOLD exit edge.
- `busy` falls on the cycle after the HOLD exit when the FIFO is empty. `busy` does not cover timer recovery.
- Throughput limit: with the FIFO full, `req_ready` rises on the cycle after a pop.

## Test plan
- Reset mid-STROBE: `rst` held 1 cycle → next cycle `bus_wr_n`=1, `bus_cs_n`=3'b111, `busy`=0, `req_ready`=1 one cycle after `rst` falls.
- YM1 a0=0 data 0x07, then YM1 a0=1 data 0x38 → two 8-cycle shapes with CS[0] low. The second SETUP starts 161 cycles after the first HOLD exit. `bus_d`=0x07 then 0x38.
- YM1 a0=1, then SAA a0=0 data 0x1C → the SAA transaction starts one cycle after the YM1 HOLD exit, not 781 cycles later. CS[2] is low for 8 cycles.
- Push 9 YM2 writes back-to-back with `FIFO_DEPTH`=8 → `req_ready`=0 after the 8th accept. The 9th is accepted one cycle after the first pop. All 9 appear on the bus in order.
- Request with chip=3 → `err_drop` pulses exactly 1 cycle, no CS activity, FIFO count unchanged.
- Queue 4 writes, assert `flush` during the first transaction's STROBE → the first completes its 8-cycle shape, the rest are never issued, and `busy` falls after its HOLD.
